// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble counter.
// Load-use detection is built only when ID_EX_HAZARD_DETECT_EN is defined.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_in,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic [1:0]        id_alusrc1,
  input  logic [1:0]        id_alusrc2,
  input  logic [3:0]        id_aluop,
  output logic              ex_valid,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic [1:0]        ex_alusrc1,
  output logic [1:0]        ex_alusrc2,
  output logic [3:0]        ex_aluop,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic              valid;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic [1:0]        alusrc1;
    logic [1:0]        alusrc2;
    logic [3:0]        aluop;
  } stage_t;

  stage_t id_pkt;
  stage_t ex_d;
  stage_t ex_q;
  logic   load_use;

  always_comb begin
    id_pkt          = '0;
    id_pkt.valid    = id_valid;
    id_pkt.rs       = id_rs;
    id_pkt.rt       = id_rt;
    id_pkt.rd       = id_rd;
    id_pkt.rs_data  = id_rs_data;
    id_pkt.rt_data  = id_rt_data;
    id_pkt.imm      = id_imm;
    id_pkt.regwrite = id_regwrite;
    id_pkt.memread  = id_memread;
    id_pkt.memwrite = id_memwrite;
    id_pkt.memtoreg = id_memtoreg;
    id_pkt.alusrc1  = id_alusrc1;
    id_pkt.alusrc2  = id_alusrc2;
    id_pkt.aluop    = id_aluop;
  end

`ifdef ID_EX_HAZARD_DETECT_EN
  logic [CNT_W-1:0] cnt_q;

  // Register 0 is hardwired, so a load targeting it can never cause a hazard.
  assign load_use = ex_q.valid & ex_q.memread & (ex_q.rt != 5'd0) & id_valid &
                    ((ex_q.rt == id_rs) | (ex_q.rt == id_rt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!flush && !stall_in && load_use && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bubble_cnt = cnt_q;
`else
  assign load_use   = 1'b0;
  assign bubble_cnt = '0;
`endif

  assign hazard_stall = load_use & ~flush;

  // An invalid ID slot loads as an all-zero bubble so forwarding never matches it.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (stall_in) begin
      ex_d = ex_q;
    end else if (load_use || !id_valid) begin
      ex_d = '0;
    end else begin
      ex_d = id_pkt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_rs       = ex_q.rs;
  assign ex_rt       = ex_q.rt;
  assign ex_rd       = ex_q.rd;
  assign ex_rs_data  = ex_q.rs_data;
  assign ex_rt_data  = ex_q.rt_data;
  assign ex_imm      = ex_q.imm;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_memread  = ex_q.memread;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_memtoreg = ex_q.memtoreg;
  assign ex_alusrc1  = ex_q.alusrc1;
  assign ex_alusrc2  = ex_q.alusrc2;
  assign ex_aluop    = ex_q.aluop;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table, scoreboard queue and
// hand-written stall / reset / counter-saturation sequences.
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int CW = 8;  // narrow counter keeps saturation reachable in a short run
`ifdef ID_EX_HAZARD_DETECT_EN
  localparam bit HD = 1'b1;
`else
  localparam bit HD = 1'b0;
`endif

  typedef struct packed {
    logic          stall;
    logic          flush;
    logic          valid;
    logic [4:0]    rs, rt, rd;
    logic [DW-1:0] rs_data, rt_data, imm;
    logic          rw, mr, mw, mt;
    logic [1:0]    a1, a2;
    logic [3:0]    op;
  } in_t;

  typedef struct packed {
    logic          valid;
    logic [4:0]    rs, rt, rd;
    logic [DW-1:0] rs_data, rt_data, imm;
    logic          rw, mr, mw, mt;
    logic [1:0]    a1, a2;
    logic [3:0]    op;
    logic [CW-1:0] cnt;
  } ex_t;

  typedef struct {
    in_t in;
    bit  exp_haz;
  } vec_t;

  logic          clk, rst_n, stall_in, flush, id_valid;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic          id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic [1:0]    id_alusrc1, id_alusrc2;
  logic [3:0]    id_aluop;
  logic          ex_valid;
  logic [4:0]    ex_rs, ex_rt, ex_rd;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm;
  logic          ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
  logic [1:0]    ex_alusrc1, ex_alusrc2;
  logic [3:0]    ex_aluop;
  logic          hazard_stall;
  logic [CW-1:0] bubble_cnt;

  int   total = 0;
  int   bad   = 0;
  ex_t  cur;
  ex_t  sb[$];
  vec_t vecs[$];

  id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .id_alusrc1(id_alusrc1), .id_alusrc2(id_alusrc2), .id_aluop(id_aluop),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .ex_alusrc1(ex_alusrc1), .ex_alusrc2(ex_alusrc2), .ex_aluop(ex_aluop),
    .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mk(bit st, bit fl, bit v, int rs, int rt, int rd,
                             bit mr, bit mw, bit rw, bit mt);
    in_t r;
    r.stall = st; r.flush = fl; r.valid = v;
    r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd);
    r.rs_data = $urandom; r.rt_data = $urandom; r.imm = $urandom;
    r.rw = rw; r.mr = mr; r.mw = mw; r.mt = mt;
    r.a1 = 2'($urandom_range(0, 3)); r.a2 = 2'($urandom_range(0, 3));
    r.op = 4'($urandom_range(0, 15));
    return r;
  endfunction

  // Reference behaviour: flush > stall > load-use > load (invalid loads as bubble).
  function automatic ex_t model(ex_t c, in_t v);
    ex_t n;
    bit  lu;
    lu = HD && c.valid && c.mr && (c.rt != 0) && v.valid &&
         ((c.rt == v.rs) || (c.rt == v.rt));
    if (v.flush) begin
      n = '0; n.cnt = c.cnt;
    end else if (v.stall) begin
      n = c;
    end else if (lu) begin
      n = '0;
      n.cnt = (c.cnt == {CW{1'b1}}) ? c.cnt : c.cnt + 1'b1;
    end else if (!v.valid) begin
      n = '0; n.cnt = c.cnt;
    end else begin
      n = '{valid: 1'b1, rs: v.rs, rt: v.rt, rd: v.rd, rs_data: v.rs_data,
            rt_data: v.rt_data, imm: v.imm, rw: v.rw, mr: v.mr, mw: v.mw,
            mt: v.mt, a1: v.a1, a2: v.a2, op: v.op, cnt: c.cnt};
    end
    return n;
  endfunction

  function automatic ex_t dut_state();
    return '{valid: ex_valid, rs: ex_rs, rt: ex_rt, rd: ex_rd,
             rs_data: ex_rs_data, rt_data: ex_rt_data, imm: ex_imm,
             rw: ex_regwrite, mr: ex_memread, mw: ex_memwrite,
             mt: ex_memtoreg, a1: ex_alusrc1, a2: ex_alusrc2, op: ex_aluop,
             cnt: bubble_cnt};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    stall_in = v.stall; flush = v.flush; id_valid = v.valid;
    id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
    id_rs_data = v.rs_data; id_rt_data = v.rt_data; id_imm = v.imm;
    id_regwrite = v.rw; id_memread = v.mr; id_memwrite = v.mw;
    id_memtoreg = v.mt; id_alusrc1 = v.a1; id_alusrc2 = v.a2; id_aluop = v.op;
  endtask

  // Called at a falling edge; checks hazard_stall, then the registered result.
  task automatic step(input string nm, input in_t v, input bit haz);
    ex_t e;
    drive(v);
    #1;
    chk({nm, ".hazard_stall"}, 256'(hazard_stall), 256'(HD & haz));
    sb.push_back(model(cur, v));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s.scoreboard: got empty expected entry", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, ".ex_state"}, 256'(dut_state()), 256'(e));
      cur = e;
    end
    @(negedge clk);
  endtask

  initial begin
    cur = '0;
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #3;
    chk("reset.ex_state", 256'(dut_state()), 256'(ex_t'('0)));
    chk("reset.hazard_stall", 256'(hazard_stall), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    //                 st fl v  rs rt rd mr mw rw mt        haz
    vecs.push_back('{mk(0, 0, 1, 1, 8, 0, 1, 0, 1, 1), 1'b0}); // lw $8
    vecs.push_back('{mk(0, 0, 1, 8, 2, 9, 0, 0, 1, 0), 1'b1}); // add uses $8
    vecs.push_back('{mk(0, 0, 1, 8, 2, 9, 0, 0, 1, 0), 1'b0}); // retry after bubble
    vecs.push_back('{mk(0, 0, 1, 4, 0, 0, 1, 0, 1, 1), 1'b0}); // lw $0
    vecs.push_back('{mk(0, 0, 1, 0, 0, 3, 0, 0, 1, 0), 1'b0}); // reads $0: no hazard
    vecs.push_back('{mk(0, 0, 1, 2, 5, 0, 1, 0, 1, 1), 1'b0}); // lw $5
    vecs.push_back('{mk(0, 1, 1, 3, 5, 7, 0, 0, 1, 0), 1'b0}); // load-use with flush
    vecs.push_back('{mk(0, 0, 1, 2, 7, 0, 1, 0, 1, 1), 1'b0}); // lw $7
    vecs.push_back('{mk(0, 0, 0, 7, 7, 4, 0, 0, 1, 0), 1'b0}); // invalid id
    vecs.push_back('{mk(0, 0, 1, 2, 7, 0, 1, 0, 1, 1), 1'b0}); // lw $7
    vecs.push_back('{mk(0, 0, 1, 4, 7, 0, 0, 1, 0, 0), 1'b1}); // sw hazard via rt
    vecs.push_back('{mk(0, 0, 1, 4, 7, 0, 0, 1, 0, 0), 1'b0});
    vecs.push_back('{mk(0, 0, 1, 9, 10, 11, 0, 0, 1, 0), 1'b0});
    vecs.push_back('{mk(0, 1, 0, 1, 2, 3, 0, 0, 1, 0), 1'b0}); // flush, no hazard

    foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i].in, vecs[i].exp_haz);

    // stall for three edges while ID changes, release on the fourth
    step("stall.load", mk(0, 0, 1, 3, 4, 5, 0, 0, 1, 0), 1'b0);
    for (int i = 0; i < 3; i++)
      step($sformatf("stall.hold%0d", i),
           mk(1, 0, 1, 10 + i, 14 + i, 18 + i, i % 2, 0, 1, 0), 1'b0);
    step("stall.release", mk(0, 0, 1, 12, 13, 14, 0, 0, 1, 0), 1'b0);

    // stalled load-use: stall requested, but contents and count held
    step("stlu.lw", mk(0, 0, 1, 1, 6, 0, 1, 0, 1, 1), 1'b0);
    step("stlu.hold", mk(1, 0, 1, 6, 2, 3, 0, 0, 1, 0), 1'b1);
    step("stlu.go", mk(0, 0, 1, 6, 2, 3, 0, 0, 1, 0), 1'b1);

    // asynchronous reset between edges while stalled
    drive(mk(1, 0, 1, 6, 7, 8, 0, 0, 1, 0));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.ex_state", 256'(dut_state()), 256'(ex_t'('0)));
    chk("rst_mid.hazard_stall", 256'(hazard_stall), 256'(0));
    #1 rst_n = 1'b1;
    cur = '0;
    @(negedge clk);
    step("rst_mid.hold", mk(1, 0, 1, 6, 7, 8, 0, 0, 1, 0), 1'b0);
    step("rst_mid.load", mk(0, 0, 1, 6, 7, 8, 0, 0, 1, 0), 1'b0);

    // drive bubble_cnt past all-ones
    for (int unsigned i = 0; i < (1 << CW); i++) begin
      step("sat.lw", mk(0, 0, 1, 1, 8, 0, 1, 0, 1, 1), 1'b0);
      step("sat.use", mk(0, 0, 1, 2, 8, 9, 0, 0, 1, 0), 1'b1);
    end
    chk("sat.final_cnt", 256'(bubble_cnt), 256'(HD ? {CW{1'b1}} : {CW{1'b0}}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register-file and immediate data width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the hazard-bubble counter.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-005 SHALL have port stall_in, input, 1, meaning downstream stall; hold all stage contents.
REQ-006 SHALL have port flush, input, 1, meaning a taken branch or jump; kill the ID instruction.
REQ-007 SHALL have port id_valid, input, 1, meaning ID holds a real instruction.
REQ-008 SHALL have ports id_rs, id_rt, id_rd, input, 5 each, meaning register specifiers from decode.
REQ-009 SHALL have ports id_rs_data, id_rt_data, id_imm, input, DATA_W each, meaning operands and the sign-extended immediate.
REQ-010 SHALL have ports id_regwrite, id_memread, id_memwrite, id_memtoreg, input, 1 each, meaning decoded control bits.
REQ-011 SHALL have ports id_alusrc1, id_alusrc2, input, 2 each, and id_aluop, input, 4, meaning ALU operand select and operation.
REQ-012 SHALL have ports ex_valid, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc1, ex_alusrc2, ex_aluop, output, widths as the matching id_ inputs, meaning registered EX-stage copies feeding the forwarding unit and ALU.
REQ-013 SHALL have port hazard_stall, output, 1, meaning combinational stall request to the PC and IF/ID register.
REQ-014 SHALL have port bubble_cnt, output, CNT_W, meaning the number of load-use bubbles inserted.

Function
REQ-015 SHALL evaluate load_use = ex_valid & ex_memread & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt)).
REQ-016 SHALL drive hazard_stall = load_use & ~flush, combinationally with zero latency.
REQ-017 SHALL apply per-edge priority: flush > stall_in > load_use > normal load.
REQ-018 SHALL, on flush, load a bubble regardless of stall_in or load_use.
REQ-019 SHALL, on stall_in without flush, hold every ex_ output unchanged, with bubble_cnt also unchanged.
REQ-020 SHALL, on load_use without flush or stall_in, load a bubble and increment bubble_cnt by 1.
REQ-021 SHALL, otherwise, load every ex_ field from its id_ counterpart, with ex_valid = id_valid, one-cycle latency.
REQ-022 SHALL define a bubble as ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg = 0 and ex_rs/ex_rt/ex_rd = 0, so forwarding never matches; data, alusrc and aluop fields cleared to 0.
REQ-023 SHALL, when id_valid = 0 on a normal load, force all control bits and specifiers to 0, giving the same result as a bubble.
REQ-024 SHALL saturate bubble_cnt at all-ones, with no wrap-around.
REQ-025 SHALL treat register 0 as never hazardous, per REQ-015.

Reset
REQ-026 SHALL, while rst_n = 0, immediately clear all ex_ outputs and bubble_cnt to 0, independent of clk.
REQ-027 SHALL keep hazard_stall = 0 during reset, because ex_valid = 0.
REQ-028 SHALL resume normal loading on the first rising clk after rst_n returns high; a reset asserted mid-stall discards the held instruction.

Configuration
REQ-029 SHALL use macro ID_EX_HAZARD_DETECT_EN to select load-use detection.
REQ-030 SHALL, with ID_EX_HAZARD_DETECT_EN defined, implement REQ-015 through REQ-020 and REQ-024 as written.
REQ-031 SHALL, without ID_EX_HAZARD_DETECT_EN, tie load_use to 0, tie hazard_stall to 0, and tie bubble_cnt to 0; flush and stall_in behave identically.

Verification
REQ-032 SHALL cover: lw $8 in EX (ex_memread=1, ex_rt=8), ID add with id_rs=8 -> hazard_stall=1 same cycle; next edge ex_valid=0, ex_regwrite=0, bubble_cnt=1.
REQ-033 SHALL cover: ex_memread=1, ex_rt=0, id_rs=0 -> hazard_stall=0; ID instruction loads normally.
REQ-034 SHALL cover: load_use=1 and flush=1 on the same cycle -> hazard_stall=0; bubble loaded; bubble_cnt unchanged.
REQ-035 SHALL cover: stall_in=1 for 3 cycles with id_ fields changing -> ex_ fields equal the pre-stall values throughout; load occurs on the 4th edge.
REQ-036 SHALL cover: bubble_cnt preloaded to 0xFFFF via 65535 load-use events, then one more -> bubble_cnt stays 0xFFFF.
REQ-037 SHALL cover: rst_n pulsed low between clk edges during stall_in=1 -> all ex_ outputs and bubble_cnt go 0 before the next edge.
